sdram_seq: RTL and testbench

- Timing sequencer for the SDRAM command generator.
- Runs the power-up init sequence, then in idle arbitrates between write requests, read requests and periodic auto-refresh.
- Outputs are init_state, work_state, cnt_clk and sdram_rd_wr, which the command block decodes into SDRAM commands.
- Also produces the data-window acks consumed by the write and read FIFOs.

---
 rtl/sdram_seq_pkg.sv | 24 ++
 rtl/sdram_ref_timer.sv | 22 ++
 rtl/sdram_seq.sv | 118 +++++++++++
 tb/tb_sdram_seq.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_seq_pkg.sv
// sdram_seq_pkg: state codes, SDRAM command codes and burst-length helpers for the sequencer
package sdram_seq_pkg;
  typedef enum logic [4:0] {
    I_NOP = 5'd0, I_PRE = 5'd1, I_TRP = 5'd2, I_AR = 5'd3,
    I_TRF = 5'd4, I_MRS = 5'd5, I_TRSC = 5'd6, I_DONE = 5'd7
  } init_state_e;
  typedef enum logic [3:0] {
    W_IDLE = 4'd0, W_ACTIVE = 4'd1, W_TRCD = 4'd2, W_READ = 4'd3, W_CL = 4'd4,
    W_RD = 4'd5, W_WRITE = 4'd6, W_WD = 4'd7, W_TWR = 4'd8, W_PRE = 4'd9,
    W_TRP = 4'd10, W_AR = 4'd11, W_TRFC = 4'd12
  } work_state_e;
  typedef enum logic [3:0] {
    CMD_LMR = 4'b0000, CMD_A_REF = 4'b0001, CMD_PRGE = 4'b0010, CMD_ACTIVE = 4'b0011,
    CMD_WRITE = 4'b0100, CMD_READ = 4'b0101, CMD_BSTOP = 4'b0110, CMD_NOP = 4'b0111,
    CMD_INIT = 4'b1111
  } sdram_cmd_e;
  localparam logic [9:0] FULL_PAGE = 10'd512;
  function automatic logic [9:0] burst_len(input logic [9:0] b);
    return b == '0 ? 10'd1 : (b > FULL_PAGE ? FULL_PAGE : b);
  endfunction
  function automatic logic burst_last(input logic [9:0] cnt, input logic [9:0] len);
    return cnt == len - 10'd1;
  endfunction
endpackage

// File: rtl/sdram_ref_timer.sv
// sdram_ref_timer: free-running refresh interval counter with a sticky pending flag
module sdram_ref_timer
  import sdram_seq_pkg::*;
#(
  parameter int REF_PERIOD = 390
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic ref_pend
);
  localparam int RW = $clog2(REF_PERIOD);
  localparam logic [RW-1:0] LAST = RW'(REF_PERIOD - 1);
  logic [RW-1:0] cnt;
  logic expire;
  assign expire = en && cnt == LAST;
  always_ff @(posedge clk) begin
    cnt <= (rst || !en || expire) ? '0 : cnt + RW'(1);
    ref_pend <= !rst && (expire || (ref_pend && !clr));
  end
endmodule

// File: rtl/sdram_seq.sv
// sdram_seq: SDRAM init/refresh/read/write timing sequencer; define SDRAM_RR_ARB_EN for round-robin rd/wr arbitration
module sdram_seq
  import sdram_seq_pkg::*;
#(
  parameter int INIT_WAIT  = 10000,
  parameter int TRP_CLK    = 4,
  parameter int TRC_CLK    = 6,
  parameter int TRSC_CLK   = 6,
  parameter int TRCD_CLK   = 2,
  parameter int CAS_LAT    = 3,
  parameter int TWR_CLK    = 2,
  parameter int AR_TIMES   = 8,
  parameter int REF_PERIOD = 390
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sdram_wr_req,
  input  logic       sdram_rd_req,
  input  logic [9:0] sdram_wr_burst,
  input  logic [9:0] sdram_rd_burst,
  output logic       sdram_wr_ack,
  output logic       sdram_rd_ack,
  output logic       sdram_init_done,
  output logic [4:0] init_state,
  output logic [3:0] work_state,
  output logic [9:0] cnt_clk,
  output logic       sdram_rd_wr
);
  localparam int CW = $clog2(INIT_WAIT) > 10 ? $clog2(INIT_WAIT) : 10;
  localparam logic [CW-1:0] T_INIT = CW'(INIT_WAIT - 1);
  localparam logic [CW-1:0] T_TRP  = CW'(TRP_CLK - 1);
  localparam logic [CW-1:0] T_TRC  = CW'(TRC_CLK - 1);
  localparam logic [CW-1:0] T_TRSC = CW'(TRSC_CLK - 1);
  localparam logic [CW-1:0] T_TRCD = CW'(TRCD_CLK - 1);
  localparam logic [CW-1:0] T_CAS  = CW'(CAS_LAT - 1);
  localparam logic [CW-1:0] T_TWR  = CW'(TWR_CLK - 1);
  localparam logic [7:0]    AR_N   = 8'(AR_TIMES);
  init_state_e ist, ist_n;
  work_state_e wst, wst_n;
  logic [CW-1:0] cnt;
  logic [7:0] ar_cnt;
  logic [9:0] blen;
  logic ref_pend, grant, wr_win;
  assign grant = wst == W_IDLE && ist == I_DONE && !ref_pend && (sdram_wr_req || sdram_rd_req);
`ifdef SDRAM_RR_ARB_EN
  logic last_rd;
  assign wr_win = sdram_wr_req && (!sdram_rd_req || last_rd);
  always_ff @(posedge clk)
    if (rst) last_rd <= 1'b1;
    else if (grant) last_rd <= !wr_win;
`else
  assign wr_win = sdram_wr_req;
`endif
  sdram_ref_timer #(.REF_PERIOD(REF_PERIOD)) u_ref (
    .clk(clk),
    .rst(rst),
    .en(ist == I_DONE),
    .clr(wst_n == W_AR),
    .ref_pend(ref_pend)
  );
  always_comb begin
    ist_n = ist;
    case (ist)
      I_NOP:   if (cnt == T_INIT) ist_n = I_PRE;
      I_PRE:   ist_n = I_TRP;
      I_TRP:   if (cnt == T_TRP) ist_n = I_AR;
      I_AR:    ist_n = I_TRF;
      I_TRF:   if (cnt == T_TRC) ist_n = ar_cnt == AR_N ? I_MRS : I_AR;
      I_MRS:   ist_n = I_TRSC;
      I_TRSC:  if (cnt == T_TRSC) ist_n = I_DONE;
      default: ist_n = I_DONE;
    endcase
  end
  always_comb begin
    wst_n = wst;
    case (wst)
      W_IDLE:   wst_n = (ist == I_DONE && ref_pend) ? W_AR : grant ? W_ACTIVE : W_IDLE;
      W_ACTIVE: wst_n = W_TRCD;
      W_TRCD:   if (cnt == T_TRCD) wst_n = sdram_rd_wr ? W_READ : W_WRITE;
      W_READ:   wst_n = W_CL;
      W_CL:     if (cnt == T_CAS) wst_n = W_RD;
      W_RD:     if (burst_last(cnt[9:0], blen)) wst_n = W_PRE;
      W_WRITE:  wst_n = blen == 10'd1 ? W_TWR : W_WD;
      W_WD:     if (burst_last(cnt[9:0], blen - 10'd1)) wst_n = W_TWR;
      W_TWR:    if (cnt == T_TWR) wst_n = W_PRE;
      W_PRE:    wst_n = W_TRP;
      W_TRP:    if (cnt == T_TRP) wst_n = W_IDLE;
      W_AR:     wst_n = W_TRFC;
      W_TRFC:   if (cnt == T_TRC) wst_n = W_IDLE;
      default:  wst_n = W_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      ist <= I_NOP;
      wst <= W_IDLE;
      cnt <= '0;
      ar_cnt <= '0;
      blen <= 10'd1;
      sdram_rd_wr <= 1'b1;
      sdram_init_done <= 1'b0;
    end else begin
      ist <= ist_n;
      wst <= wst_n;
      cnt <= (ist_n != ist || wst_n != wst) ? '0 : cnt + CW'(1);
      ar_cnt <= ar_cnt + 8'(ist == I_AR);
      sdram_init_done <= ist_n == I_DONE;
      if (grant) begin
        sdram_rd_wr <= !wr_win;
        blen <= burst_len(wr_win ? sdram_wr_burst : sdram_rd_burst);
      end else if (wst_n == W_IDLE) sdram_rd_wr <= 1'b1;
    end
  assign sdram_wr_ack = wst == W_WRITE || wst == W_WD;
  assign sdram_rd_ack = wst == W_RD;
  assign init_state = ist;
  assign work_state = wst;
  assign cnt_clk = cnt[9:0];
endmodule

// File: tb/tb_sdram_seq.sv
// tb_sdram_seq: directed and random checks of sdram_seq against a transaction-level timing model
module tb_sdram_seq;
  localparam int T0 = 88;
  localparam int REF = 390;
  logic clk = 1'b0, rst = 1'b1;
  logic sdram_wr_req = 1'b0, sdram_rd_req = 1'b0;
  logic [9:0] sdram_wr_burst = '0, sdram_rd_burst = '0;
  logic sdram_wr_ack, sdram_rd_ack, sdram_init_done, sdram_rd_wr;
  logic [4:0] init_state;
  logic [3:0] work_state;
  logic [9:0] cnt_clk;
  always #5 clk = ~clk;
  sdram_seq #(.INIT_WAIT(20)) dut (
    .clk(clk),
    .rst(rst),
    .sdram_wr_req(sdram_wr_req),
    .sdram_rd_req(sdram_rd_req),
    .sdram_wr_burst(sdram_wr_burst),
    .sdram_rd_burst(sdram_rd_burst),
    .sdram_wr_ack(sdram_wr_ack),
    .sdram_rd_ack(sdram_rd_ack),
    .sdram_init_done(sdram_init_done),
    .init_state(init_state),
    .work_state(work_state),
    .cnt_clk(cnt_clk),
    .sdram_rd_wr(sdram_rd_wr)
  );
  typedef struct packed {
    logic [3:0] ws;
    logic [9:0] cnt;
    logic rw;
    logic wa;
    logic ra;
  } exp_t;
  exp_t q[$];
  exp_t cur;
  logic [4:0] init_ws[$];
  logic [9:0] init_c[$];
  int t, errs, checks, idle_cnt, wa_n, ra_n, cl_n, arw_n, rw0_n, ar_seen;
  bit prev_idle, pend, found;
`ifdef SDRAM_RR_ARB_EN
  bit last_rd;
`endif
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask
  function automatic int clampb(input int b);
    return b == 0 ? 1 : (b > 512 ? 512 : b);
  endfunction
  function automatic logic [9:0] rand_burst();
    int k = $urandom_range(0, 19);
    return k == 0 ? 10'd0 : k == 1 ? 10'd1 : k == 2 ? 10'd2 :
           k == 3 ? 10'($urandom_range(513, 1023)) : 10'($urandom_range(3, 24));
  endfunction
  task automatic push_init(input logic [4:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      init_ws.push_back(s);
      init_c.push_back(10'(i));
    end
  endtask
  task automatic push_seg(input logic [3:0] ws, input int n, input logic rw);
    for (int i = 0; i < n; i++)
      q.push_back('{ws, 10'(i), rw, ws == 4'd6 || ws == 4'd7, ws == 4'd5});
  endtask
  task automatic cycle(input bit wr, input bit rd, input logic [9:0] wb, input logic [9:0] rb);
    bit idle, w;
    logic [4:0] ei;
    if (t >= T0 + REF && (t - T0) % REF == 0) pend = 1'b1;
    idle = t >= T0 && q.size() == 0;
    ei = 5'd7;
    if (t < T0) begin
      ei = init_ws[t];
      cur = '{4'd0, init_c[t], 1'b1, 1'b0, 1'b0};
    end else if (idle) begin
      idle_cnt = prev_idle ? idle_cnt + 1 : 0;
      cur = '{4'd0, 10'(idle_cnt), 1'b1, 1'b0, 1'b0};
    end else cur = q.pop_front();
    prev_idle = idle;
    chk("state", {init_state, work_state}, {ei, cur.ws});
    chk("cnt_clk", cnt_clk, cur.cnt);
    chk("ctl", {sdram_init_done, sdram_rd_wr, sdram_wr_ack, sdram_rd_ack},
        {t >= T0, cur.rw, cur.wa, cur.ra});
    wa_n += int'(sdram_wr_ack);
    ra_n += int'(sdram_rd_ack);
    cl_n += int'(work_state == 4'd4);
    arw_n += int'(work_state == 4'd11);
    rw0_n += int'(!sdram_rd_wr);
    ar_seen += int'(init_state == 5'd3);
    sdram_wr_req = wr;
    sdram_rd_req = rd;
    sdram_wr_burst = wb;
    sdram_rd_burst = rb;
    if (idle) begin
      if (pend) begin
        pend = 1'b0;
        push_seg(4'd11, 1, 1'b1);
        push_seg(4'd12, 6, 1'b1);
      end else if (wr || rd) begin
`ifdef SDRAM_RR_ARB_EN
        w = wr && (!rd || last_rd);
        last_rd = !w;
`else
        w = wr;
`endif
        push_seg(4'd1, 1, !w);
        push_seg(4'd2, 2, !w);
        if (w) begin
          push_seg(4'd6, 1, 1'b0);
          push_seg(4'd7, clampb(int'(wb)) - 1, 1'b0);
          push_seg(4'd8, 2, 1'b0);
        end else begin
          push_seg(4'd3, 1, 1'b1);
          push_seg(4'd4, 3, 1'b1);
          push_seg(4'd5, clampb(int'(rb)), 1'b1);
        end
        push_seg(4'd9, 1, !w);
        push_seg(4'd10, 4, !w);
      end
    end
  endtask
  task automatic tick(input bit wr, input bit rd, input logic [9:0] wb, input logic [9:0] rb);
    @(posedge clk);
    #1;
    t++;
    cycle(wr, rd, wb, rb);
  endtask
  task automatic drain(input bit wr, input bit rd, input logic [9:0] wb, input logic [9:0] rb);
    int n = 0;
    while (q.size() > 0 && n < 3000) begin
      tick(wr, rd, wb, rb);
      n++;
    end
    chk("drain_bound", q.size(), 0);
  endtask
  initial begin
    push_init(5'd0, 20);
    push_init(5'd1, 1);
    push_init(5'd2, 4);
    for (int i = 0; i < 8; i++) begin
      push_init(5'd3, 1);
      push_init(5'd4, 6);
    end
    push_init(5'd5, 1);
    push_init(5'd6, 6);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_state", {init_state, work_state}, 9'd0);
      chk("rst_cnt", cnt_clk, 10'd0);
      chk("rst_ctl", {sdram_init_done, sdram_rd_wr, sdram_wr_ack, sdram_rd_ack}, 4'b0100);
    end
    rst = 1'b0;
    t = 0;
    pend = 1'b0;
    prev_idle = 1'b0;
`ifdef SDRAM_RR_ARB_EN
    last_rd = 1'b1;
`endif
    cycle(1'b0, 1'b0, '0, '0);
    while (t < T0 - 1)
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_burst(), rand_burst());
    chk("init_ar_count", ar_seen, 8);
    wa_n = 0;
    rw0_n = 0;
    tick(1'b1, 1'b0, 10'd10, '0);
    drain(1'b0, 1'b0, '0, '0);
    chk("wr10_ack_cycles", wa_n, 10);
    chk("wr10_rdwr_low", rw0_n, 20);
    ra_n = 0;
    cl_n = 0;
    tick(1'b0, 1'b1, '0, 10'd1);
    drain(1'b0, 1'b0, '0, '0);
    chk("rd1_ack_cycles", ra_n, 1);
    chk("rd1_cl_cycles", cl_n, 3);
    tick(1'b1, 1'b1, 10'd4, 10'd4);
    tick(1'b0, 1'b0, '0, '0);
    chk("tie1_grant_rdwr", sdram_rd_wr, 1'b0);
    drain(1'b0, 1'b0, '0, '0);
    tick(1'b1, 1'b1, 10'd3, 10'd3);
    tick(1'b0, 1'b0, '0, '0);
`ifdef SDRAM_RR_ARB_EN
    chk("tie2_grant_rdwr", sdram_rd_wr, 1'b1);
`else
    chk("tie2_grant_rdwr", sdram_rd_wr, 1'b0);
`endif
    drain(1'b0, 1'b0, '0, '0);
    tick(1'b1, 1'b1, 10'd2, 10'd2);
    drain(1'b0, 1'b1, '0, 10'd2);
    tick(1'b0, 1'b1, '0, 10'd2);
    tick(1'b0, 1'b0, '0, '0);
    chk("read_next_rdwr", sdram_rd_wr, 1'b1);
    drain(1'b0, 1'b0, '0, '0);
    while (t < 420) tick(1'b0, 1'b0, '0, '0);
    arw_n = 0;
    ra_n = 0;
    tick(1'b0, 1'b1, '0, 10'd512);
    drain(1'b1, 1'b0, 10'd0, '0);
    chk("rd512_ack_cycles", ra_n, 512);
    chk("ref_deferred", arw_n, 0);
    tick(1'b1, 1'b0, 10'd0, '0);
    tick(1'b1, 1'b0, 10'd0, '0);
    chk("ref_first", work_state, 4'd11);
    drain(1'b1, 1'b0, 10'd0, '0);
    wa_n = 0;
    tick(1'b1, 1'b0, 10'd0, '0);
    drain(1'b0, 1'b0, '0, '0);
    chk("wr0_ack_cycles", wa_n, 1);
    chk("ref_merged", arw_n, 1);
    repeat (1500)
      tick($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, rand_burst(), rand_burst());
    drain(1'b0, 1'b0, '0, '0);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick(1'b0, 1'b1, '0, 10'd30);
      found = cur.ws == 4'd5 && cur.cnt == 10'd5;
    end
    chk("reach_rd", found, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_init_state", init_state, 5'd0);
    chk("midrst_work_state", work_state, 4'd0);
    chk("midrst_rd_ack", sdram_rd_ack, 1'b0);
    chk("midrst_init_done", sdram_init_done, 1'b0);
    chk("midrst_cnt", cnt_clk, 10'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
